// File: rtl/eth_rx_parser.sv
// eth_rx_parser
//   Receive-side Ethernet header parser. Consumes 64-bit AXI-stream frames
//   carrying a 14-byte Ethernet header, filters on destination MAC, strips
//   the header and re-emits the payload realigned to byte lane 0.
//
// Parameters
//   MAC_ADDR_FPGA  local MAC address; frames addressed here are accepted
//   ACCEPT_BCAST   1: broadcast destination is also accepted
//
// Ports
//   ap_clk, ap_rst_n             clock, async active-low reset
//   stream_in_*                  network-side input stream (DATA/KEEP/LAST/VALID/READY)
//   stream_out_*                 realigned payload stream (registered)
//   meta_dst_mac/src_mac/ethertype  header fields captured on flit 1
//   stat_frames_ok/filtered/runt    frame counters
//
// Configuration
//   ETH_RX_STATS_EN  defined: 32-bit wrapping frame counters are built.
//                    undefined: stat_* are tied to 0 and no counter flops exist.
module eth_rx_parser #(
    parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02,
    parameter bit          ACCEPT_BCAST  = 1'b1
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [63:0] stream_in_DATA,
    input  logic [7:0]  stream_in_KEEP,
    input  logic        stream_in_LAST,
    input  logic        stream_in_VALID,
    output logic        stream_in_READY,
    output logic [63:0] stream_out_DATA,
    output logic [7:0]  stream_out_KEEP,
    output logic        stream_out_LAST,
    output logic        stream_out_VALID,
    input  logic        stream_out_READY,
    output logic [47:0] meta_dst_mac,
    output logic [47:0] meta_src_mac,
    output logic [15:0] meta_ethertype,
    output logic [31:0] stat_frames_ok,
    output logic [31:0] stat_frames_filtered,
    output logic [31:0] stat_frames_runt
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [MAC_W-1:0] BCAST_MAC = 48'hffff_ffff_ffff;

    typedef enum logic [2:0] {
        HDR0    = 3'd0,
        HDR1    = 3'd1,
        PAYLOAD = 3'd2,
        TAIL    = 3'd3,
        DROP    = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Low only between reset release and the first clock edge; keeps READY at 0 in reset.
    logic              active;
    logic [MAC_W-1:0]  dst_q, dst_nxt;
    logic [RES_W-1:0]  src_hi_q, src_hi_nxt;
    logic [RES_W-1:0]  res_q, res_nxt;
    logic [1:0]        res_cnt_q, res_cnt_nxt;

    logic [DATA_W-1:0] out_data_nxt;
    logic [KEEP_W-1:0] out_keep_nxt;
    logic              out_last_nxt;
    logic              out_valid_nxt;
    logic [MAC_W-1:0]  meta_dst_nxt, meta_src_nxt;
    logic [RES_W-1:0]  meta_type_nxt;

    logic              in_ready_c;
    logic              out_free_c;
    logic              dst_match_c;
    logic [CNT_W-1:0]  n_in_c;
    logic [DATA_W-1:0] realigned_c;
    logic [KEEP_W-1:0] keep_short_c;
    logic              ev_ok, ev_filt, ev_runt;

    function automatic logic [CNT_W-1:0] popcnt(input logic [KEEP_W-1:0] k);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + CNT_W'(k[i]);
        return c;
    endfunction

    // Expand a byte-valid mask into a bit mask so unused lanes are zeroed.
    function automatic logic [DATA_W-1:0] byte_mask(input logic [KEEP_W-1:0] k);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    assign stream_in_READY = in_ready_c;
    assign out_free_c      = !stream_out_VALID || stream_out_READY;
    assign dst_match_c     = (dst_q == MAC_ADDR_FPGA) || (ACCEPT_BCAST && (dst_q == BCAST_MAC));
    assign ev_ok           = stream_out_VALID && stream_out_READY && stream_out_LAST;

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_nxt     = state;
        in_ready_c    = 1'b0;
        dst_nxt       = dst_q;
        src_hi_nxt    = src_hi_q;
        res_nxt       = res_q;
        res_cnt_nxt   = res_cnt_q;
        out_data_nxt  = stream_out_DATA;
        out_keep_nxt  = stream_out_KEEP;
        out_last_nxt  = stream_out_LAST;
        out_valid_nxt = stream_out_VALID && !stream_out_READY;
        meta_dst_nxt  = meta_dst_mac;
        meta_src_nxt  = meta_src_mac;
        meta_type_nxt = meta_ethertype;
        ev_filt       = 1'b0;
        ev_runt       = 1'b0;
        n_in_c        = popcnt(stream_in_KEEP);
        // Residual supplies lanes 0-1, input lanes 0-5 fill lanes 2-7.
        realigned_c   = {stream_in_DATA[47:0], res_q};
        keep_short_c  = KEEP_W'((9'd1 << (n_in_c + 4'd2)) - 9'd1);

        case (state)
            HDR0: begin
                in_ready_c = active;
                if (stream_in_VALID && in_ready_c) begin
                    dst_nxt    = {stream_in_DATA[7:0],   stream_in_DATA[15:8],
                                  stream_in_DATA[23:16], stream_in_DATA[31:24],
                                  stream_in_DATA[39:32], stream_in_DATA[47:40]};
                    src_hi_nxt = {stream_in_DATA[55:48], stream_in_DATA[63:56]};
                    if (stream_in_LAST) ev_runt = 1'b1;
                    else                state_nxt = HDR1;
                end
            end

            HDR1: begin
                in_ready_c = active;
                if (stream_in_VALID && in_ready_c) begin
                    meta_dst_nxt  = dst_q;
                    meta_src_nxt  = {src_hi_q,
                                     stream_in_DATA[7:0],   stream_in_DATA[15:8],
                                     stream_in_DATA[23:16], stream_in_DATA[31:24]};
                    meta_type_nxt = {stream_in_DATA[39:32], stream_in_DATA[47:40]};
                    res_nxt       = stream_in_DATA[63:48];
                    if (!dst_match_c) begin
                        ev_filt   = 1'b1;
                        state_nxt = stream_in_LAST ? HDR0 : DROP;
                    end else if (stream_in_LAST) begin
                        if (!stream_in_KEEP[6]) begin
                            ev_runt   = 1'b1;
                            state_nxt = HDR0;
                        end else begin
                            res_cnt_nxt = 2'(n_in_c - 4'd6);
                            if (n_in_c == 4'd7) res_nxt[15:8] = 8'h00;
                            state_nxt = TAIL;
                        end
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                // Accept only when the output register can take the produced flit.
                in_ready_c = active && out_free_c;
                if (stream_in_VALID && in_ready_c) begin
                    out_valid_nxt = 1'b1;
                    res_nxt       = stream_in_DATA[63:48];
                    if (!stream_in_LAST) begin
                        out_data_nxt = realigned_c;
                        out_keep_nxt = 8'hff;
                        out_last_nxt = 1'b0;
                    end else if (n_in_c <= 4'd6) begin
                        out_data_nxt = realigned_c & byte_mask(keep_short_c);
                        out_keep_nxt = keep_short_c;
                        out_last_nxt = 1'b1;
                        state_nxt    = HDR0;
                    end else begin
                        out_data_nxt = realigned_c;
                        out_keep_nxt = 8'hff;
                        out_last_nxt = 1'b0;
                        res_cnt_nxt  = 2'(n_in_c - 4'd6);
                        if (n_in_c == 4'd7) res_nxt[15:8] = 8'h00;
                        state_nxt    = TAIL;
                    end
                end
            end

            TAIL: begin
                if (out_free_c) begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = {48'h0, res_q};
                    out_keep_nxt  = (res_cnt_q == 2'd1) ? 8'h01 : 8'h03;
                    out_last_nxt  = 1'b1;
                    state_nxt     = HDR0;
                end
            end

            DROP: begin
                in_ready_c = active;
                if (stream_in_VALID && in_ready_c && stream_in_LAST) state_nxt = HDR0;
            end

            default: state_nxt = HDR0;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state            <= HDR0;
            active           <= 1'b0;
            dst_q            <= '0;
            src_hi_q         <= '0;
            res_q            <= '0;
            res_cnt_q        <= '0;
            stream_out_DATA  <= '0;
            stream_out_KEEP  <= '0;
            stream_out_LAST  <= 1'b0;
            stream_out_VALID <= 1'b0;
            meta_dst_mac     <= '0;
            meta_src_mac     <= '0;
            meta_ethertype   <= '0;
        end else begin
            state            <= state_nxt;
            active           <= 1'b1;
            dst_q            <= dst_nxt;
            src_hi_q         <= src_hi_nxt;
            res_q            <= res_nxt;
            res_cnt_q        <= res_cnt_nxt;
            stream_out_DATA  <= out_data_nxt;
            stream_out_KEEP  <= out_keep_nxt;
            stream_out_LAST  <= out_last_nxt;
            stream_out_VALID <= out_valid_nxt;
            meta_dst_mac     <= meta_dst_nxt;
            meta_src_mac     <= meta_src_nxt;
            meta_ethertype   <= meta_type_nxt;
        end
    end

`ifdef ETH_RX_STATS_EN
    // Per-frame wrapping counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stat_frames_ok       <= '0;
            stat_frames_filtered <= '0;
            stat_frames_runt     <= '0;
        end else begin
            if (ev_ok)   stat_frames_ok       <= stat_frames_ok + 32'd1;
            if (ev_filt) stat_frames_filtered <= stat_frames_filtered + 32'd1;
            if (ev_runt) stat_frames_runt     <= stat_frames_runt + 32'd1;
        end
    end
`else
    assign stat_frames_ok       = '0;
    assign stat_frames_filtered = '0;
    assign stat_frames_runt     = '0;
    logic unused_stats;
    assign unused_stats = ev_ok | ev_filt | ev_runt;
`endif

endmodule
